wb_cmd_master: RTL

//  Downstream of the UART-to-command decoder. Consumes 34-bit command words {cmd[1:0], value[31:0]} and their one-cycle valid strobe.

---
 rtl/wb_cmd_pkg.sv | 12 +
 rtl/wb_cmd_pend_buf.sv | 29 ++
 rtl/wb_cmd_master.sv | 109 ++++++++++
 3 files changed

// File: rtl/wb_cmd_pkg.sv
// wb_cmd_pkg: command codes, FSM states and command word layout for wb_cmd_master
package wb_cmd_pkg;
  localparam logic [1:0] CMD_RD  = 2'b00;
  localparam logic [1:0] CMD_WR  = 2'b01;
  localparam logic [1:0] CMD_ADR = 2'b10;
  localparam logic [1:0] CMD_SET = 2'b11;
  typedef enum logic [1:0] {IDLE, BUS, RESP} wbm_state_t;
  typedef struct packed {
    logic [1:0]  cmd;
    logic [31:0] val;
  } cmd_word_t;
endpackage

// File: rtl/wb_cmd_pend_buf.sv
// wb_cmd_pend_buf: one-entry command holding buffer with sticky overflow flag
module wb_cmd_pend_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [33:0] din,
  input  logic        push,
  input  logic        pop,
  input  logic        ovf_clr,
  output logic        full,
  output logic [33:0] dout,
  output logic        overflow
);
  logic take, drop;
  always_comb begin
    take = push & (~full | pop);
    drop = push & full & ~pop;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 1'b0;
      dout     <= '0;
      overflow <= 1'b0;
    end else begin
      full     <= take | (full & ~pop);
      dout     <= take ? din : dout;
      overflow <= drop | (overflow & ~ovf_clr);
    end
  end
endmodule

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: executes decoded UART commands as register updates or Wishbone classic single cycles
module wb_cmd_master import wb_cmd_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_INC       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [33:0] cmd_word,
  input  logic        cmd_valid,
  input  logic        ovf_clr,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        overflow
);
  wbm_state_t state, state_n;
  cmd_word_t  pend;
  logic        pend_full, pop, launch, done, fail;
  logic [31:0] addr_r;
  logic [3:0]  sel_r;
  logic        autoinc_r;
  logic [15:0] cnt;
  wb_cmd_pend_buf u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (cmd_word),
    .push     (cmd_valid),
    .pop      (pop),
    .ovf_clr  (ovf_clr),
    .full     (pend_full),
    .dout     (pend),
    .overflow (overflow)
  );
  assign busy = (state != IDLE) | pend_full;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    launch  = 1'b0;
    done    = 1'b0;
    fail    = 1'b0;
    case (state)
      IDLE: begin
        pop     = pend_full;
        launch  = pend_full & ~pend.cmd[1];
        state_n = launch ? BUS : IDLE;
      end
      BUS: begin
        fail    = wb_err_i | (~wb_ack_i & (cnt == 16'(TIMEOUT_CYCLES - 1)));
        done    = wb_ack_i | fail;
        state_n = done ? RESP : BUS;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r    <= '0;
      sel_r     <= 4'hF;
      autoinc_r <= 1'b0;
      cnt       <= '0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= 4'hF;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (pop && pend.cmd == CMD_ADR) addr_r <= pend.val;
      if (pop && pend.cmd == CMD_SET) begin
        sel_r     <= pend.val[3:0];
        autoinc_r <= pend.val[4];
      end
      if (state == RESP && !rsp_err && autoinc_r) addr_r <= addr_r + 32'(ADDR_INC);
      if (launch) begin
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
        wb_we_o  <= pend.cmd == CMD_WR;
        wb_adr_o <= addr_r;
        wb_dat_o <= pend.val;
        wb_sel_o <= sel_r;
      end
      if (done) begin
        wb_cyc_o <= 1'b0;
        wb_stb_o <= 1'b0;
        rsp_err  <= fail;
        rsp_data <= (fail | wb_we_o) ? 32'h0 : wb_dat_i;
      end
      cnt       <= (state == BUS) ? cnt + 16'd1 : 16'd0;
      rsp_valid <= done;
    end
  end
endmodule
